// File: rtl/s_sum_acc_if.sv
// Stream bundle for the s_sum_acc accumulation stage.
// Input side : sum_in (5-bit two's complement), in_valid, in_last, in_ready.
// Output side: acc_out, acc_cnt, sat, out_valid, out_ready.
// master: the environment (upstream sequencer plus downstream consumer).
// slave : the accumulator itself.
interface s_sum_acc_if #(
  parameter int unsigned ACC_W   = 12,
  parameter int unsigned MAX_CNT = 16
);
  localparam int unsigned CNT_W = $clog2(MAX_CNT + 1);

  logic [4:0]       sum_in;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [ACC_W-1:0] acc_out;
  logic [CNT_W-1:0] acc_cnt;
  logic             sat;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output sum_in, in_valid, in_last, out_ready,
    input  in_ready, acc_out, acc_cnt, sat, out_valid
  );

  modport slave (
    input  sum_in, in_valid, in_last, out_ready,
    output in_ready, acc_out, acc_cnt, sat, out_valid
  );
endinterface

// File: rtl/s_sum_acc.sv
// Saturating frame accumulator for the signed 4-bit adder sums.
// Accepts one 5-bit two's-complement beat per cycle, accumulates up to MAX_CNT beats per frame
// into an ACC_W-bit clamped register and holds the frame total until downstream takes it.
// Ports:
//   clk   : clock, all state on its rising edge
//   rst_n : asynchronous active-low reset
//   bus   : s_sum_acc_if slave (beat input handshake + frame result handshake)
module s_sum_acc #(
  parameter int unsigned ACC_W   = 12,
  parameter int unsigned MAX_CNT = 16
) (
  input logic        clk,
  input logic        rst_n,
  s_sum_acc_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(MAX_CNT + 1);

  typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  logic [ACC_W:0]   sum_ext;
  logic [ACC_W:0]   acc_sum;
  logic [CNT_W-1:0] cnt_inc;
  logic             ovf;
  logic             accept;

  // One guard bit above ACC_W is enough: |acc| + 16 cannot wrap ACC_W+1 bits.
  assign sum_ext = {{(ACC_W + 1 - 5){bus.sum_in[4]}}, bus.sum_in};
  assign acc_sum = {acc_q[ACC_W-1], acc_q} + sum_ext;
  assign ovf     = acc_sum[ACC_W] ^ acc_sum[ACC_W-1];
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign accept  = bus.in_valid && (state_q != StDone);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    unique case (state_q)
      StIdle, StAcc: begin
        if (accept) begin
          if (ovf) begin
            // Sign of the wide sum tells which rail was crossed.
            acc_d = acc_sum[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
            sat_d = 1'b1;
          end else begin
            acc_d = acc_sum[ACC_W-1:0];
          end
          cnt_d   = cnt_inc;
          state_d = (bus.in_last || (cnt_inc == CNT_W'(MAX_CNT))) ? StDone : StAcc;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        acc_d   = '0;
        cnt_d   = '0;
        sat_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  // Every output comes from registers only; in_ready deliberately ignores out_ready.
  assign bus.in_ready  = (state_q != StDone);
  assign bus.out_valid = (state_q == StDone);
  assign bus.acc_out   = acc_q;
  assign bus.acc_cnt   = cnt_q;
  assign bus.sat       = sat_q;
endmodule

// File: tb/tb_s_sum_acc.sv
// Testbench for s_sum_acc: two instances (ACC_W=12/MAX_CNT=16 and ACC_W=6/MAX_CNT=5),
// directed steps followed by random traffic, checked against an integer frame model.
module tb_s_sum_acc;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  s_sum_acc_if #(.ACC_W(12), .MAX_CNT(16)) if_a ();
  s_sum_acc_if #(.ACC_W(6),  .MAX_CNT(5))  if_b ();

  s_sum_acc #(.ACC_W(12), .MAX_CNT(16)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  s_sum_acc #(.ACC_W(6),  .MAX_CNT(5))  u_dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

  int checks = 0;
  int passes = 0;

  // Frame model: plain integers, clamped after each accepted beat.
  int acc_w   [2] = '{12, 6};
  int max_cnt [2] = '{16, 5};
  int m_acc   [2];
  int m_cnt   [2];
  bit m_sat   [2];
  bit m_done  [2];

  function automatic void chk(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endfunction

  function automatic void model_clear(int id);
    m_acc[id]  = 0;
    m_cnt[id]  = 0;
    m_sat[id]  = 1'b0;
    m_done[id] = 1'b0;
  endfunction

  function automatic void model_edge(int id, bit v, bit l, int s, bit r);
    int hi, lo, t;
    hi = (1 << (acc_w[id] - 1)) - 1;
    lo = -(1 << (acc_w[id] - 1));
    if (!m_done[id]) begin
      if (v) begin
        t = m_acc[id] + s;
        if (t > hi) begin t = hi; m_sat[id] = 1'b1; end
        if (t < lo) begin t = lo; m_sat[id] = 1'b1; end
        m_acc[id] = t;
        m_cnt[id] = m_cnt[id] + 1;
        if (l || m_cnt[id] == max_cnt[id]) m_done[id] = 1'b1;
      end
    end else if (r) begin
      model_clear(id);
    end
  endfunction

  task automatic drive(int id, bit v, bit l, int s, bit r);
    if (id == 0) begin
      if_a.in_valid = v; if_a.in_last = l; if_a.sum_in = 5'(s); if_a.out_ready = r;
    end else begin
      if_b.in_valid = v; if_b.in_last = l; if_b.sum_in = 5'(s); if_b.out_ready = r;
    end
  endtask

  task automatic check_dut(int id, string tag);
    logic               ov, ir, st;
    logic signed [31:0] acc, cnt;
    if (id == 0) begin
      ov = if_a.out_valid; ir = if_a.in_ready; st = if_a.sat;
      acc = $signed(if_a.acc_out); cnt = {27'd0, if_a.acc_cnt};
    end else begin
      ov = if_b.out_valid; ir = if_b.in_ready; st = if_b.sat;
      acc = $signed(if_b.acc_out); cnt = {29'd0, if_b.acc_cnt};
    end
    chk({tag, ".out_valid"}, {31'd0, ov}, {31'd0, m_done[id]});
    chk({tag, ".in_ready"},  {31'd0, ir}, {31'd0, !m_done[id]});
    chk({tag, ".acc_out"},   acc, m_acc[id]);
    chk({tag, ".acc_cnt"},   cnt, m_cnt[id]);
    chk({tag, ".sat"},       {31'd0, st}, {31'd0, m_sat[id]});
  endtask

  // Check state left by the previous edge, apply new inputs, then advance the model by one edge.
  task automatic cycle(int id, bit v, bit l, int s, bit r, string tag);
    @(negedge clk);
    check_dut(id, tag);
    drive(id, v, l, s, r);
    @(posedge clk);
    if (rst_n) model_edge(id, v, l, s, r);
  endtask

  initial begin
    bit v, l, r;
    int s;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    model_clear(0);
    model_clear(1);
    #12;
    check_dut(0, "reset_a");
    check_dut(1, "reset_b");
    @(negedge clk);
    rst_n = 1'b1;

    // Short frame: +7, -3, +15(last) -> 19, then DONE ignores further beats.
    cycle(0, 1, 0, 7, 0, "short");
    cycle(0, 1, 0, -3, 0, "short");
    cycle(0, 1, 1, 15, 0, "short");
    cycle(0, 1, 1, 5, 0, "short_done");
    cycle(0, 1, 0, -9, 0, "ignored");
    cycle(0, 0, 1, 0, 1, "ignored");
    cycle(0, 0, 0, 0, 0, "drain_short");

    // Auto-close after 16 beats of -16, then a 5-cycle stall with a +1 beat waiting.
    for (int i = 0; i < 16; i++) cycle(0, 1, 0, -16, 0, "autoclose");
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 1, 0, "stall");
    cycle(0, 1, 0, 1, 1, "handshake");
    cycle(0, 1, 0, 1, 0, "after_hs");
    cycle(0, 1, 1, 0, 0, "next_beat");
    cycle(0, 0, 0, 0, 1, "next_done");
    cycle(0, 0, 0, 0, 0, "next_idle");

    // Narrow accumulator: positive clamp then recovery, then negative clamp.
    cycle(1, 1, 0, 15, 0, "sat_pos");
    cycle(1, 1, 0, 15, 0, "sat_pos");
    cycle(1, 1, 0, 15, 0, "sat_pos");
    cycle(1, 1, 1, -16, 0, "sat_pos");
    cycle(1, 0, 0, 0, 1, "sat_pos_done");
    cycle(1, 1, 0, -16, 0, "sat_neg");
    cycle(1, 1, 0, -16, 0, "sat_neg");
    cycle(1, 1, 1, -16, 0, "sat_neg");
    cycle(1, 0, 0, 0, 1, "sat_neg_done");
    // Auto-close at MAX_CNT=5, result left pending for the reset test.
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 2, 0, "cnt5");
    cycle(1, 0, 0, 0, 0, "cnt5_hold");

    // Reset mid-frame on A (in_valid high) and during DONE on B.
    cycle(0, 1, 0, 3, 0, "pre_rst");
    cycle(0, 1, 0, 3, 0, "pre_rst");
    @(negedge clk);
    drive(0, 1, 0, 3, 0);
    #2 rst_n = 1'b0;
    model_clear(0);
    model_clear(1);
    #1;
    check_dut(0, "midrst_a");
    check_dut(1, "midrst_b");
    @(posedge clk);
    #1 drive(0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 1, 1, 2, 0, "post_rst");
    cycle(0, 0, 0, 0, 1, "post_rst_done");
    cycle(0, 0, 0, 0, 0, "post_rst_idle");
    cycle(1, 0, 0, 0, 0, "post_rst_b");

    // Random traffic on both instances.
    for (int id = 0; id < 2; id++) begin
      for (int i = 0; i < 300; i++) begin
        v = ($urandom_range(0, 3) != 0);
        l = ($urandom_range(0, 5) == 0);
        r = ($urandom_range(0, 1) == 1);
        s = int'($urandom_range(0, 31)) - 16;
        cycle(id, v, l, s, r, "rand");
      end
      cycle(id, 0, 0, 0, 1, "rand_drain");
      cycle(id, 0, 0, 0, 1, "rand_drain");
      cycle(id, 0, 0, 0, 0, "rand_end");
    end

    @(negedge clk);
    check_dut(0, "final_a");
    check_dut(1, "final_b");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
